// File: rtl/sequential_divider.sv
// sequential_divider: restoring unsigned divider, one quotient bit per clock over WIDTH cycles.
// Define SEQ_DIVIDER_DIV_ZERO_EN for a one-cycle divide-by-zero path with the divByZero flag.
module sequential_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             quotientDone,
    output logic             divByZero
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] q, d, r;
    logic [WIDTH:0]   rs, t;

    // partial remainder stays below the divisor, so its extra top bit is always zero and is not stored
    assign rs = {r, q[WIDTH-1]};
    assign t  = rs - {1'b0, d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            q     <= '0;
            r     <= '0;
            d     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    q     <= dividend;
                    d     <= divisor;
                    r     <= '0;
                    count <= '0;
                    state <= ITER;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
                    if (divisor == '0) begin
                        q     <= '1;
                        r     <= dividend;
                        state <= DONE;
                    end
`endif
                end
                ITER: begin
                    r     <= t[WIDTH] ? rs[WIDTH-1:0] : t[WIDTH-1:0];
                    q     <= {q[WIDTH-2:0], ~t[WIDTH]};
                    count <= count + 1'b1;
                    state <= (count == CW'(WIDTH - 1)) ? DONE : ITER;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_DIVIDER_DIV_ZERO_EN
    logic dbz;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dbz <= 1'b0;
        else if (state == IDLE && start) dbz <= (divisor == '0);
    end
    assign divByZero = dbz;
`else
    assign divByZero = 1'b0;
`endif

    assign quotient     = q;
    assign remainder    = r;
    assign quotientDone = (state == DONE);
endmodule
